seq_sorter: RTL and testbench
=============================

SEQ_SORTER -- requirements
Module: seq_sorter

Interface
REQ-001 Parameter N, default 4, meaning number of elements; legal values are N >= 2.
REQ-002 Parameter W, default 4, meaning element width in bits; legal values are W >= 1.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 nrst  input  1  synchronous reset, active-low.
REQ-005 in_valid  input  1  producer presents a vector on in_data.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 in_data  input  N*W  unsorted vector; element k occupies bits [W*k+W-1 : W*k].
REQ-008 out_valid  output  1  sorted vector is present on out_data.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  N*W  sorted vector, using the same element packing as in_data.
REQ-011 desc  input  1  descending-order select; this port exists only when SEQ_SORTER_DESC_EN is defined.

Function
REQ-012 The block SHALL implement an FSM with three states: IDLE, SORT and DONE.
REQ-013 IDLE: in_ready=1 and out_valid=0; when in_valid=1, the block captures in_data into an internal array, clears phase counter cnt to 0 and moves to SORT.
REQ-014 SORT: in_ready=0 and out_valid=0; each cycle executes one odd-even transposition phase, then increments cnt.
REQ-015 A phase with even cnt SHALL compare-exchange pairs (0,1), (2,3), ...; a phase with odd cnt SHALL compare-exchange pairs (1,2), (3,4), ...; for odd N, the unpaired element is held.
REQ-016 In ascending order, an exchange SHALL occur only if element[j] > element[j+1] (strict, unsigned), so that after sorting element 0 is the minimum; equal elements are never exchanged.
REQ-017 cnt SHALL be $clog2(N)+1 bits wide, which holds the value N without wrap.
REQ-018 After phase cnt=N-1 executes, the block SHALL move to DONE; exactly N phases run regardless of data.
REQ-019 Latency: if a vector is accepted on edge k, out_valid SHALL be 1 from edge k+N onward.
REQ-020 DONE: out_valid=1 and in_ready=0; out_data SHALL hold stable while out_ready=0, for an unbounded time.
REQ-021 On an edge with out_valid=1 and out_ready=1, the block SHALL return to IDLE; the next vector can be accepted one cycle later, with no overlap between vectors.
REQ-022 in_valid outside IDLE SHALL be ignored, and in_data SHALL not be sampled.
REQ-023 out_data SHALL equal the internal array in every state; its contents are meaningful only while out_valid=1.

Reset
REQ-024 When nrst=0 on a rising edge, the block SHALL enter IDLE, clear cnt to 0, clear the array to all zeros (so out_data=0), and set out_valid=0 and in_ready=1 from the next cycle.
REQ-025 A reset during SORT or DONE SHALL discard the vector in flight, and no out_valid pulse SHALL follow.
REQ-026 Reset SHALL take priority over any simultaneous in_valid or out_ready.

Configuration
REQ-027 Macro SEQ_SORTER_DESC_EN, when defined, SHALL add the desc port; desc is sampled once at acceptance into a register, and a registered 1 inverts the comparison to element[j] < element[j+1].
REQ-028 A desc change after acceptance SHALL not affect the vector in flight.
REQ-029 Without SEQ_SORTER_DESC_EN, the block SHALL have no desc port and SHALL sort ascending only, with no extra register.

Verification
REQ-030 N=4, W=4: input elements e0..e3 = 9,2,7,0 accepted on edge k -> out_valid rises at edge k+4 with out_data e0..e3 = 0,2,7,9.
REQ-031 N=4: inputs 15,14,13,12 -> output 12,13,14,15; input 5,5,5,5 -> output 5,5,5,5; input 1,2,3,4 -> output unchanged; in all three cases latency is 4.
REQ-032 N=5, W=8: input 200,3,77,3,0 -> output 0,3,3,77,200 at edge k+5.
REQ-033 Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid stays 1, out_data stays constant, and in_ready stays 0; a new in_valid during this time is ignored.
REQ-034 Reset mid-operation: assert nrst=0 at edge k+2 of SORT -> next cycle in_ready=1, out_valid=0, out_data=0, and no later out_valid pulse occurs.
REQ-035 With SEQ_SORTER_DESC_EN defined and desc=1 at acceptance, input 9,2,7,0 -> output 9,7,2,0, and toggling desc during SORT has no effect.

Source files
------------

// File: rtl/seq_sorter.sv
// Iterative odd-even transposition sorter: one phase per cycle, N phases per vector.
// Optional descending mode enabled by defining SEQ_SORTER_DESC_EN.
module seq_sorter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef SEQ_SORTER_DESC_EN
    input  logic           desc,
`endif
    output logic [N*W-1:0] out_data
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  arr    [N];
    logic [W-1:0]  phased [N];
`ifdef SEQ_SORTER_DESC_EN
    logic          desc_q;
`endif

    // One compare-exchange phase; even cnt pairs (0,1),(2,3)..., odd cnt pairs (1,2),(3,4)...
    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            phased[k] = arr[k];
        end
        for (int j = 0; j < int'(N) - 1; j++) begin
            if (1'(j) == cnt[0]) begin
`ifdef SEQ_SORTER_DESC_EN
                if (desc_q ? (arr[j] < arr[j+1]) : (arr[j] > arr[j+1])) begin
`else
                if (arr[j] > arr[j+1]) begin
`endif
                    phased[j]   = arr[j+1];
                    phased[j+1] = arr[j];
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            out_data[W*k +: W] = arr[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                arr[k] <= '0;
            end
`ifdef SEQ_SORTER_DESC_EN
            desc_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < int'(N); k++) begin
                            arr[k] <= in_data[W*k +: W];
                        end
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SORT;
`ifdef SEQ_SORTER_DESC_EN
                        desc_q   <= desc;
`endif
                    end
                end
                SORT: begin
                    for (int k = 0; k < int'(N); k++) begin
                        arr[k] <= phased[k];
                    end
                    cnt <= cnt + CW'(1);
                    // Fixed N phases, independent of data
                    if (cnt == CW'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sorter.sv
// Directed bench for seq_sorter: N=4/W=4 and N=5/W=8 instances sharing clock and reset.
module tb_seq_sorter;

    logic        clk = 1'b0;
    logic        nrst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [15:0] in_data4, out_data4;
`ifdef SEQ_SORTER_DESC_EN
    logic        desc4;
`endif

    logic        in_valid5, in_ready5, out_valid5, out_ready5;
    logic [39:0] in_data5, out_data5;
`ifdef SEQ_SORTER_DESC_EN
    logic        desc5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_sorter #(.N(4), .W(4)) dut4 (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4),
`ifdef SEQ_SORTER_DESC_EN
        .desc(desc4),
`endif
        .out_data(out_data4)
    );

    seq_sorter #(.N(5), .W(8)) dut5 (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5),
`ifdef SEQ_SORTER_DESC_EN
        .desc(desc5),
`endif
        .out_data(out_data5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] p4(input int e0, input int e1, input int e2, input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a vector on dut4, check latency N=4, result and the return to IDLE
    task automatic run4(input string tag, input logic [15:0] vin, input logic [15:0] vexp);
        in_valid4 = 1'b1;
        in_data4  = vin;
        step();
        in_valid4 = 1'b0;
        chk({tag, "_busy"}, 64'(in_ready4), 64'(0));
        for (int i = 1; i < 4; i++) begin
            step();
            chk({tag, "_early"}, 64'(out_valid4), 64'(0));
        end
        step();
        chk({tag, "_valid"}, 64'(out_valid4), 64'(1));
        chk({tag, "_data"}, 64'(out_data4), 64'(vexp));
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        chk({tag, "_idle_rdy"}, 64'(in_ready4), 64'(1));
        chk({tag, "_idle_vld"}, 64'(out_valid4), 64'(0));
    endtask

    initial begin
        nrst = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_data4 = '0;
        in_valid5 = 1'b0; out_ready5 = 1'b0; in_data5 = '0;
`ifdef SEQ_SORTER_DESC_EN
        desc4 = 1'b0; desc5 = 1'b0;
`endif
        step();
        step();
        chk("rst_in_ready", 64'(in_ready4), 64'(1));
        chk("rst_out_valid", 64'(out_valid4), 64'(0));
        chk("rst_out_data", 64'(out_data4), 64'(0));

        // Reset wins over a simultaneous in_valid
        in_valid4 = 1'b1;
        in_data4  = p4(3, 3, 3, 3);
        step();
        in_valid4 = 1'b0;
        chk("rst_prio_rdy", 64'(in_ready4), 64'(1));
        chk("rst_prio_data", 64'(out_data4), 64'(0));
        nrst = 1'b1;
        step();

        run4("v9270", p4(9, 2, 7, 0), p4(0, 2, 7, 9));
        run4("vdesc", p4(15, 14, 13, 12), p4(12, 13, 14, 15));
        run4("vsame", p4(5, 5, 5, 5), p4(5, 5, 5, 5));
        run4("vsorted", p4(1, 2, 3, 4), p4(1, 2, 3, 4));

        // N=5, W=8
        in_valid5 = 1'b1;
        in_data5  = {8'd0, 8'd3, 8'd77, 8'd3, 8'd200};
        step();
        in_valid5 = 1'b0;
        for (int i = 1; i < 5; i++) begin
            step();
            chk("n5_early", 64'(out_valid5), 64'(0));
        end
        step();
        chk("n5_valid", 64'(out_valid5), 64'(1));
        chk("n5_data", 64'(out_data5), 64'({8'd200, 8'd77, 8'd3, 8'd3, 8'd0}));
        out_ready5 = 1'b1;
        step();
        out_ready5 = 1'b0;
        chk("n5_idle", 64'(in_ready5), 64'(1));

        // Backpressure: hold DONE for 6 cycles while a stray in_valid is presented
        in_valid4 = 1'b1;
        in_data4  = p4(8, 1, 6, 3);
        step();
        in_valid4 = 1'b0;
        repeat (4) step();
        in_valid4 = 1'b1;
        in_data4  = p4(15, 15, 15, 15);
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 64'(out_valid4), 64'(1));
            chk("bp_data", 64'(out_data4), 64'(p4(1, 3, 6, 8)));
            chk("bp_ready", 64'(in_ready4), 64'(0));
            step();
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        chk("bp_release", 64'(out_valid4), 64'(0));

        // Reset during SORT: accept at edge k, reset sampled at edge k+2
        in_valid4 = 1'b1;
        in_data4  = p4(9, 2, 7, 0);
        step();
        in_valid4 = 1'b0;
        step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("mid_rst_rdy", 64'(in_ready4), 64'(1));
        chk("mid_rst_vld", 64'(out_valid4), 64'(0));
        chk("mid_rst_data", 64'(out_data4), 64'(0));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid_rst_quiet", 64'(out_valid4), 64'(0));
        end

`ifdef SEQ_SORTER_DESC_EN
        // Descending with desc toggled mid-sort
        desc4 = 1'b1;
        in_valid4 = 1'b1;
        in_data4  = p4(9, 2, 7, 0);
        step();
        in_valid4 = 1'b0;
        desc4 = 1'b0;
        step();
        desc4 = 1'b1;
        step();
        desc4 = 1'b0;
        step();
        step();
        chk("desc_valid", 64'(out_valid4), 64'(1));
        chk("desc_data", 64'(out_data4), 64'(p4(9, 7, 2, 0)));
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
